// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin burst arbiter sharing one FIFO push port among N_REQ producers
module fifo_push_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DW-1:0]        data_in,
  output logic [N_REQ-1:0]           ack,
  input  logic                       fifo_full,
  output logic                       fifo_push,
  output logic [DW-1:0]              fifo_data,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;
  logic          state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, owner_q, owner_d, win;
  logic [CW-1:0] beat_q, beat_d;
  logic          accept, last, exit_g;
  // scan from the highest offset down so the closest requester to rr_q wins
  always_comb begin
    win = rr_q;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[(int'(rr_q) + k) % N_REQ]) win = IW'((int'(rr_q) + k) % N_REQ);
  end
  assign busy      = state_q == GRANT;
  assign accept    = busy && req[owner_q] && !fifo_full;
  assign last      = beat_q == CW'(MAX_BURST - 1);
  assign exit_g    = busy && (!req[owner_q] || (accept && last));
  assign fifo_push = accept;
  assign ack       = accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << owner_q) : '0;
  assign fifo_data = busy ? data_in[int'(owner_q)*DW +: DW] : '0;
  assign grant_id  = owner_q;
  always_comb begin
    state_d = busy ? (exit_g ? IDLE : GRANT) : (|req ? GRANT : IDLE);
    owner_d = (!busy && |req) ? win : owner_q;
    beat_d  = (!busy || exit_g) ? '0 : accept ? beat_q + 1'b1 : beat_q;
    rr_d    = exit_g ? (owner_q == IW'(N_REQ - 1) ? '0 : owner_q + 1'b1) : rr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
    end
  end
  assert property (@(posedge clk) disable iff (rst) fifo_push |-> !fifo_full);
  assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
  assert property (@(posedge clk) disable iff (rst) fifo_push == |ack);
  assert property (@(posedge clk) disable iff (rst) beat_q < CW'(MAX_BURST));
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: randomized scoreboard bench with a transaction-level arbitration model
module tb_fifo_push_arbiter;
  localparam int N = 4, DW = 8, MB = 4, IW = 2;
  logic clk = 0, rst = 1, fifo_full = 0;
  logic [N-1:0] req = '0, ack;
  logic [N*DW-1:0] data_in = '0;
  logic fifo_push, busy;
  logic [DW-1:0] fifo_data;
  logic [IW-1:0] grant_id;
  logic [2:0] req3 = '0, ack3;
  logic [3*DW-1:0] data3 = {8'hC2, 8'hC1, 8'hC0};
  logic push3, busy3;
  logic [DW-1:0] fdata3;
  logic [1:0] gid3;

  fifo_push_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .ack(ack), .fifo_full(fifo_full),
    .fifo_push(fifo_push), .fifo_data(fifo_data), .grant_id(grant_id), .busy(busy));
  fifo_push_arbiter #(.N_REQ(3), .DW(DW), .MAX_BURST(MB)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .data_in(data3), .ack(ack3), .fifo_full(1'b0),
    .fifo_push(push3), .fifo_data(fdata3), .grant_id(gid3), .busy(busy3));

  always #5 clk = ~clk;

  typedef struct {int cyc; int lane; logic [DW-1:0] data;} push_t;
  typedef struct {int cyc; int busy; int gid;} stat_t;
  push_t pq[$];
  stat_t sq[$];
  logic [DW-1:0] prod[N][$];
  int checks = 0, failures = 0, cyc = 0;
  int m_busy = 0, m_owner = 0, m_cnt = 0, m_rr = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // reference: who owns the port, how many words it has sent, and where the search starts next
  function automatic void model();
    bit acc;
    acc = m_busy != 0 && req[m_owner] && !fifo_full;
    sq.push_back('{cyc, m_busy, m_owner});
    if (acc) begin
      pq.push_back('{cyc, m_owner, prod[m_owner][0]});
      void'(prod[m_owner].pop_front());
    end
    if (rst) begin
      m_busy = 0; m_owner = 0; m_cnt = 0; m_rr = 0;
    end else if (m_busy == 0) begin
      for (int k = N - 1; k >= 0; k--)
        if (req[(m_rr + k) % N]) begin m_owner = (m_rr + k) % N; m_busy = 1; m_cnt = 0; end
    end else if (!req[m_owner] || (acc && m_cnt + 1 == MB)) begin
      m_busy = 0; m_rr = (m_owner + 1) % N;
    end else if (acc) m_cnt++;
  endfunction

  task automatic step(input bit r, input bit full_v, input int gap_pct);
    @(negedge clk);
    rst = r;
    fifo_full = full_v;
    for (int i = 0; i < N; i++) begin
      req[i] = prod[i].size() > 0 && ($urandom_range(99) >= gap_pct);
      data_in[i*DW +: DW] = prod[i].size() > 0 ? prod[i][0] : '0;
    end
    model();
    cyc++;
  endtask

  task automatic load(input int p, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) prod[p].push_back(base + DW'(i));
  endtask

  task automatic step3(input logic [2:0] r, input logic b, input int g, input logic p);
    @(negedge clk);
    req3 = r;
    #2;
    chk("n3_busy", busy3, b);
    if (b) chk("n3_grant_id", gid3, g);
    chk("n3_push", push3, p);
    if (p) chk("n3_ack", ack3, 3'b1 << g);
  endtask

  initial begin : monitor
    stat_t s;
    push_t p;
    forever begin
      @(negedge clk);
      #2;
      if (sq.size() > 0) begin
        s = sq.pop_front();
        chk("busy", busy, s.busy);
        if (s.busy != 0) chk("grant_id", grant_id, s.gid);
        else chk("idle_data", fifo_data, 0);
        if (fifo_push) begin
          if (pq.size() == 0) chk("unexpected_push", fifo_data, 64'hDEAD);
          else begin
            p = pq.pop_front();
            chk("push_cycle", s.cyc, p.cyc);
            chk("push_data", fifo_data, p.data);
            chk("push_ack", ack, 1 << p.lane);
          end
        end else if (pq.size() > 0 && pq[0].cyc == s.cyc) begin
          p = pq.pop_front();
          chk("missed_push", 0, 1);
        end else chk("idle_ack", ack, 0);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    prod[1] = {8'hA1, 8'hA2, 8'hA3};
    repeat (6) step(0, 0, 0);
    load(0, 12, 8'h10);
    repeat (16) step(0, 0, 0);
    for (int i = 0; i < N; i++) load(i, 8, 8'(8'h40 + 16 * i));
    repeat (44) step(0, 0, 0);
    load(2, 4, 8'h80);
    repeat (3) step(0, 0, 0);
    repeat (5) step(0, 1, 0);
    repeat (5) step(0, 0, 0);
    load(3, 6, 8'h90);
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    load(1, 2, 8'hB0);
    load(2, 2, 8'hB8);
    repeat (20) step(0, 0, 0);
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (prod[i].size() < 3 && $urandom_range(9) == 0) prod[i].push_back(DW'($urandom));
      step($urandom_range(99) == 0, $urandom_range(3) == 0, 20);
    end
    for (int i = 0; i < N; i++) prod[i].delete();
    repeat (4) step(0, 0, 0);
    @(negedge clk);
    #3;
    chk("scoreboard_drain", pq.size(), 0);
    rst = 0;
    step3(3'b100, 0, 0, 0);
    repeat (MB) step3(3'b100, 1, 2, 1);
    step3(3'b101, 0, 0, 0);
    step3(3'b101, 1, 0, 1);
    chk("n3_data", fdata3, 8'hC0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
